// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response port plus decode-side
// handshake. master = fetch stage, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            valid_d;
  logic            ready_d;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output valid_d, InstrD, PCD, PCPlus4D,
    input  ready_d
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  valid_d, InstrD, PCD, PCPlus4D,
    output ready_d
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with in-order imem port and prefetch FIFO.
// Ports: clk, rst (async, active-low), redirect_e/target_e, bus (master).
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] target_e,
  fetch_unit_if.master    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;

  logic [XLEN-1:0] pc_mem  [FIFO_DEPTH];
  logic [31:0]     ins_mem [FIFO_DEPTH];

  logic [XLEN-1:0] tgt;
  logic [CW:0]     credit;
  logic            req_v;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic            head_v;

  assign tgt    = target_e & ~XLEN'(3);
  // Requests in flight reserve a FIFO slot, so the FIFO cannot overflow.
  assign credit = {1'b0, cnt_q} + {1'b0, out_q};
  assign head_v = (cnt_q != '0);

  always_comb begin
    req_v    = rst & ~redirect_e & (credit < DEPTH_C);
    req_fire = req_v & bus.imem_req_ready;
    rsp_ok   = bus.imem_rsp_valid & (out_q != '0);
    push     = rsp_ok & (drop_q == '0) & ~redirect_e;
    pop      = head_v & bus.ready_d & ~redirect_e;

    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    wp_d     = wp_q;
    rp_d     = rp_q;

    if (req_fire) begin
      pc_d  = pc_q + XLEN'(4);
      out_d = out_d + CW'(1);
    end
    if (rsp_ok) begin
      out_d = out_d - CW'(1);
      if (drop_q != '0) drop_d = drop_q - CW'(1);
    end
    if (push) begin
      wp_d     = wp_q + AW'(1);
      rsp_pc_d = rsp_pc_q + XLEN'(4);
    end
    if (pop) rp_d = rp_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Everything still in flight after this cycle's response is stale.
    if (redirect_e) begin
      pc_d     = tgt;
      rsp_pc_d = tgt;
      drop_d   = out_d;
      cnt_d    = '0;
      rp_d     = wp_q;
      wp_d     = wp_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp_q]  <= rsp_pc_q;
      ins_mem[wp_q] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid = req_v;
  assign bus.imem_req_addr  = pc_q;
  assign bus.valid_d        = head_v;
  assign bus.InstrD   = head_v ? ins_mem[rp_q] : '0;
  assign bus.PCD      = head_v ? pc_mem[rp_q] : '0;
  assign bus.PCPlus4D = head_v ? pc_mem[rp_q] + XLEN'(4) : '0;

  // A response with nothing outstanding breaks the memory protocol.
  rsp_without_req: assert property (
    @(posedge clk) disable iff (!rst)
    !(bus.imem_rsp_valid && out_q == '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed bench for fetch_unit against a
// stream-level model (expected PC sequence, epochs, FIFO occupancy).
module tb_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            redirect_e = 1'b0;
  logic [XLEN-1:0] target_e = '0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN(XLEN),
    .RESET_PC(32'h0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_e(redirect_e),
    .target_e(target_e),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  int rd_pct = 100;
  int rq_mode = 0;
  req_t mq[$];
  int epoch = 0;
  int occ = 0;
  int last_due = -1;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req = '0;
  int n_acc = 0;
  int n_pop = 0;
  int acc_cyc = -1;
  int val_cyc = -1;
  bit prev_hold = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] popped[$];

  function automatic logic [31:0] memfn(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] pop_at(int i);
    if (i < popped.size()) return popped[i];
    return 'x;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memfn(mq[0].addr);
    end
    bus.ready_d = ($urandom_range(99) < rd_pct);
    case (rq_mode)
      0:       bus.imem_req_ready = 1'b1;
      1:       bus.imem_req_ready = (cyc % 2 == 0);
      default: bus.imem_req_ready = 1'($urandom_range(1));
    endcase
    redirect_e = 1'b0;
  endtask

  task automatic check_cycle();
    bit rsp, fire, pop, redir;
    req_t e;
    int due;
    redir = redirect_e;
    chk("valid_d", 32'(bus.valid_d), 32'(occ != 0));
    chk("req_valid", 32'(bus.imem_req_valid),
        32'(!redir && (occ + mq.size() < DEPTH)));
    if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req);
    if (prev_hold && bus.imem_req_valid)
      chk("addr_hold", bus.imem_req_addr, prev_addr);
    if (occ != 0) begin
      chk("PCD", bus.PCD, exp_pc);
      chk("InstrD", bus.InstrD, memfn(exp_pc));
      chk("PCPlus4D", bus.PCPlus4D, exp_pc + 32'd4);
    end else begin
      chk("empty_out", bus.PCD | bus.InstrD | bus.PCPlus4D, 32'h0);
    end

    rsp  = bus.imem_rsp_valid;
    fire = bus.imem_req_valid && bus.imem_req_ready;
    pop  = bus.valid_d && bus.ready_d && !redir;

    if (rsp) begin
      e = mq.pop_front();
      if (e.ep == epoch && !redir) occ++;
    end
    if (fire) begin
      due = cyc + 1 + lat;
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{exp_req, due, epoch});
      last_due = due;
      exp_req += 32'd4;
      n_acc++;
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    if (bus.valid_d && val_cyc < 0) val_cyc = cyc;
    if (pop && occ > 0) begin
      popped.push_back(exp_pc);
      exp_pc += 32'd4;
      occ--;
      n_pop++;
    end
    if (redir) begin
      occ = 0;
      epoch++;
      exp_pc  = target_e & ~32'h3;
      exp_req = target_e & ~32'h3;
    end
    prev_hold = bus.imem_req_valid && !bus.imem_req_ready && !redir;
    prev_addr = bus.imem_req_addr;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic redirect_now(logic [31:0] t);
    redirect_e = 1'b1;
    target_e   = t;
    #1;
  endtask

  task automatic do_reset(int hold);
    #2;
    rst = 1'b0;
    redirect_e = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("rst_valid_d", 32'(bus.valid_d), 32'h0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_InstrD", bus.InstrD, 32'h0);
    chk("rst_PCD", bus.PCD, 32'h0);
    chk("rst_PCPlus4D", bus.PCPlus4D, 32'h0);
    mq.delete();
    occ = 0;
    epoch++;
    exp_pc = '0;
    exp_req = '0;
    last_due = -1;
    prev_hold = 0;
    acc_cyc = -1;
    val_cyc = -1;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.ready_d        = 1'b0;

    // Reset and first fetches
    lat = 1; rd_pct = 100; rq_mode = 0;
    #1;
    do_reset(2);
    popped.delete();
    repeat (12) tick();
    chk("first_valid_lat", 32'(val_cyc - acc_cyc), 32'(lat + 2));
    chk("seq_pc0", pop_at(0), 32'h0);
    chk("seq_pc4", pop_at(1), 32'h4);
    chk("seq_pc8", pop_at(2), 32'h8);

    // Decode stall fills exactly DEPTH credits
    do_reset(2);
    rd_pct = 0;
    n_acc = 0;
    repeat (10) tick();
    chk("stall_reqs", 32'(n_acc), 32'(DEPTH));
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("stall_PCD", bus.PCD, 32'h0);
    rd_pct = 100;
    bus.ready_d = 1'b1;
    #1;
    n_pop = 0;
    popped.delete();
    repeat (4) tick();
    chk("drain_no_gaps", 32'(n_pop), 32'd4);
    chk("drain_last", pop_at(3), 32'hC);

    // Redirect with three fetches in flight
    do_reset(2);
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 3) found = 1;
      else tick();
    end
    chk("redir3_setup", 32'(found), 32'h1);
    redirect_now(32'h103);
    tick();
    chk("redir3_valid_d", 32'(bus.valid_d), 32'h0);
    chk("redir3_req_addr", bus.imem_req_addr, 32'h100);
    popped.delete();
    repeat (15) tick();
    chk("redir3_first_pcd", pop_at(0), 32'h100);

    // Redirect coincident with a response and a pop
    lat = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (bus.imem_rsp_valid && bus.valid_d) found = 1;
    end
    chk("coincide_setup", 32'(found), 32'h1);
    bus.ready_d = 1'b1;
    redirect_now(32'h200);
    tick();
    chk("coincide_valid_d", 32'(bus.valid_d), 32'h0);
    popped.delete();
    repeat (10) tick();
    chk("coincide_first_pcd", pop_at(0), 32'h200);

    // Request backpressure across the address wrap
    rq_mode = 1;
    redirect_now(32'hFFFF_FFF8);
    popped.delete();
    repeat (30) tick();
    chk("wrap_pc0", pop_at(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", pop_at(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", pop_at(2), 32'h0);
    chk("wrap_pc3", pop_at(3), 32'h4);

    // Reset with FIFO half full and two fetches outstanding
    lat = 3; rd_pct = 0; rq_mode = 0;
    bus.ready_d = 1'b0;
    redirect_now(32'h300);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (occ == 2 && mq.size() == 2) found = 1;
    end
    chk("midrst_setup", 32'(found), 32'h1);
    do_reset(2);
    rd_pct = 100;
    popped.delete();
    repeat (15) tick();
    chk("midrst_first_pcd", pop_at(0), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        lat     = $urandom_range(4);
        rd_pct  = 20 + $urandom_range(80);
        rq_mode = $urandom_range(2);
      end
      if ($urandom_range(99) < 4)
        redirect_now($urandom());
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
